// File: rtl/ps2_host_tx.sv
// ---------------------------------------------------------------------------
// ps2_host_tx -- PS/2 host-to-device command transmitter
//
// Sends one byte to a PS/2 device. The sequence is: clock inhibit,
// request-to-send, ten device-clocked bits (d0..d7, odd parity, stop), then
// the device ACK. PS2_CLK and PS2_DATA are driven open-drain through
// output enables. A receive path sharing the bus should ignore it while busy=1.
//
// Optional build macro: PS2_HOST_TX_RETRY_EN
//   When defined, the first failure (missing ACK or timeout) silently restarts
//   the whole sequence with the latched byte. A second failure pulses err.
//
// Ports:
//   clk          system clock
//   reset        synchronous active-high reset
//   tx_data      byte to send
//   tx_valid     send request, accepted when tx_valid && tx_ready
//   tx_ready     high only while idle
//   busy         high whenever not idle
//   done         1-cycle pulse, byte acknowledged by the device
//   err          1-cycle pulse, timeout or missing ACK
//   ps2_clk_in   raw PS2_CLK pin level
//   ps2_data_in  raw PS2_DATA pin level
//   ps2_clk_oe   1 = pull PS2_CLK low
//   ps2_data_oe  1 = pull PS2_DATA low
// ---------------------------------------------------------------------------
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 12000,
    parameter int unsigned TIMEOUT_CYCLES = 1500000,
    parameter int unsigned EDGE_TIMEOUT   = 20000,
    parameter int unsigned FILTER_LEN     = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       done,
    output logic       err,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    typedef enum logic [2:0] {
        S_IDLE, S_INHIBIT, S_REQ, S_DATA, S_PARITY, S_ACK, S_WAIT_IDLE
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  clk_sync_q, data_sync_q;
    logic        clk_filt_q, clk_filt_d;
    logic [7:0]  filt_cnt_q, filt_cnt_d;
    logic        fall;
    logic        data_sync;
    logic [7:0]  shift_q, shift_d;
    logic        par_q, par_d;
    logic [2:0]  bitcnt_q, bitcnt_d;
    logic [31:0] cyc_cnt_q, cyc_cnt_d;   // inhibit length, then cycles since last fall
    logic [31:0] tot_cnt_q, tot_cnt_d;   // cycles since clock release
    logic        clk_oe_q, clk_oe_d;
    logic        data_oe_q, data_oe_d;
    logic        active;
    logic        fail;
`ifdef PS2_HOST_TX_RETRY_EN
    logic        retry_q, retry_d;
`endif

    assign data_sync = data_sync_q[1];

    // The filtered clock only follows the synchronized pin after FILTER_LEN
    // consecutive samples disagree with it; any agreeing sample restarts the run.
    always_comb begin
        clk_filt_d = clk_filt_q;
        filt_cnt_d = '0;
        if (clk_sync_q[1] != clk_filt_q) begin
            if (filt_cnt_q == 8'(FILTER_LEN - 1)) begin
                clk_filt_d = clk_sync_q[1];
            end else begin
                filt_cnt_d = filt_cnt_q + 8'd1;
            end
        end
    end

    assign fall   = clk_filt_q & ~clk_filt_d;
    assign active = (state_q inside {S_REQ, S_DATA, S_PARITY, S_ACK, S_WAIT_IDLE});

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        par_d     = par_q;
        bitcnt_d  = bitcnt_q;
        cyc_cnt_d = cyc_cnt_q;
        tot_cnt_d = tot_cnt_q;
        clk_oe_d  = clk_oe_q;
        data_oe_d = data_oe_q;
        done      = 1'b0;
        err       = 1'b0;
        fail      = 1'b0;
`ifdef PS2_HOST_TX_RETRY_EN
        retry_d   = retry_q;
`endif
        if (active) begin
            cyc_cnt_d = fall ? '0 : cyc_cnt_q + 32'd1;
            tot_cnt_d = tot_cnt_q + 32'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (tx_valid) begin
                    shift_d   = tx_data;
                    par_d     = ~^tx_data;
                    clk_oe_d  = 1'b1;
                    cyc_cnt_d = '0;
                    state_d   = S_INHIBIT;
`ifdef PS2_HOST_TX_RETRY_EN
                    retry_d   = 1'b0;
`endif
                end
            end
            S_INHIBIT: begin
                if (cyc_cnt_q == INHIBIT_CYCLES - 1) begin
                    // Start bit and clock release happen together.
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b1;
                    cyc_cnt_d = '0;
                    tot_cnt_d = '0;
                    state_d   = S_REQ;
                end else begin
                    cyc_cnt_d = cyc_cnt_q + 32'd1;
                end
            end
            S_REQ: begin
                if (fall) begin
                    data_oe_d = ~shift_q[0];
                    bitcnt_d  = '0;
                    state_d   = S_DATA;
                end
            end
            S_DATA: begin
                if (fall) begin
                    if (bitcnt_q == 3'd7) begin
                        data_oe_d = ~par_q;
                        state_d   = S_PARITY;
                    end else begin
                        data_oe_d = ~shift_q[bitcnt_q + 3'd1];
                        bitcnt_d  = bitcnt_q + 3'd1;
                    end
                end
            end
            S_PARITY: begin
                if (fall) begin
                    data_oe_d = 1'b0;   // stop bit is the released line
                    state_d   = S_ACK;
                end
            end
            S_ACK: begin
                if (fall) begin
                    if (!data_sync) state_d = S_WAIT_IDLE;
                    else            fail    = 1'b1;
                end
            end
            S_WAIT_IDLE: begin
                if (clk_filt_q && data_sync) begin
                    done    = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (active && (tot_cnt_q >= TIMEOUT_CYCLES || cyc_cnt_q >= EDGE_TIMEOUT)) begin
            fail = 1'b1;
        end

        // Timeouts take priority over a same-cycle completion.
        if (fail) begin
            done      = 1'b0;
            err       = 1'b1;
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
            state_d   = S_IDLE;
`ifdef PS2_HOST_TX_RETRY_EN
            if (!retry_q) begin
                err       = 1'b0;
                retry_d   = 1'b1;
                clk_oe_d  = 1'b1;
                cyc_cnt_d = '0;
                state_d   = S_INHIBIT;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            clk_filt_q  <= 1'b1;
            filt_cnt_q  <= '0;
            shift_q     <= '0;
            par_q       <= 1'b0;
            bitcnt_q    <= '0;
            cyc_cnt_q   <= '0;
            tot_cnt_q   <= '0;
            clk_oe_q    <= 1'b0;
            data_oe_q   <= 1'b0;
`ifdef PS2_HOST_TX_RETRY_EN
            retry_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            clk_sync_q  <= {clk_sync_q[0], ps2_clk_in};
            data_sync_q <= {data_sync_q[0], ps2_data_in};
            clk_filt_q  <= clk_filt_d;
            filt_cnt_q  <= filt_cnt_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            bitcnt_q    <= bitcnt_d;
            cyc_cnt_q   <= cyc_cnt_d;
            tot_cnt_q   <= tot_cnt_d;
            clk_oe_q    <= clk_oe_d;
            data_oe_q   <= data_oe_d;
`ifdef PS2_HOST_TX_RETRY_EN
            retry_q     <= retry_d;
`endif
        end
    end

    assign tx_ready    = (state_q == S_IDLE);
    assign busy        = ~tx_ready;
    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// ---------------------------------------------------------------------------
// tb_ps2_host_tx -- directed bench for ps2_host_tx with a PS/2 device model.
// The device model records every frame it clocks in and compares it with the
// expected frame queue; a monitor pops the expected done/err outcome queue.
// Timing parameters are scaled down so the run stays short.
// ---------------------------------------------------------------------------
module tb_ps2_host_tx;

    localparam int INH  = 120;
    localparam int TMO  = 3000;
    localparam int EDGE = 200;
    localparam int FLEN = 4;
    localparam int HALF = 20;   // device clock half period in system cycles

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, busy, done, err, clk_oe, data_oe;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;
    logic       ps2_clk_w, ps2_data_w;

    assign ps2_clk_w  = ~(clk_oe | dev_clk_low);
    assign ps2_data_w = ~(data_oe | dev_data_low);

    int n_checks = 0;
    int n_errors = 0;
    int n_done = 0;
    int n_err = 0;
    int dev_mode = 0;   // 0 ACK, 1 never ACK, 2 silent, 3 NACK once then ACK
    int dev_falls = 0;
    bit dev_abort = 1'b0;
    logic [10:0] frame_q[$];
    logic        outcome_q[$];   // 1 = done expected, 0 = err expected

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TMO),
        .EDGE_TIMEOUT(EDGE),
        .FILTER_LEN(FLEN)
    ) dut (
        .clk(clk),
        .reset(reset),
        .tx_data(tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .busy(busy),
        .done(done),
        .err(err),
        .ps2_clk_in(ps2_clk_w),
        .ps2_data_in(ps2_data_w),
        .ps2_clk_oe(clk_oe),
        .ps2_data_oe(data_oe)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Frame bit order on the wire: [0]=start, [8:1]=d0..d7, [9]=parity, [10]=stop.
    function automatic logic [10:0] exp_frame(input logic [7:0] d);
        int   ones;
        logic p;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        p = ((ones % 2) == 0);
        return {1'b1, p, d, 1'b0};
    endfunction

    task automatic send(input logic [7:0] d);
        @(negedge clk);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic wait_outcome(input string tag, input int budget);
        int start;
        int c;
        start = n_done + n_err;
        c = 0;
        while ((n_done + n_err) == start && c < budget) begin
            @(negedge clk);
            c++;
        end
        check(tag, 32'((n_done + n_err) != start), 32'd1);
    endtask

    task automatic dev_wait(inout bit ab);
        for (int t = 0; t < HALF && !ab; t++) begin
            @(negedge clk);
            if (dev_abort) ab = 1'b1;
        end
    endtask

    // Device model: answers a request-to-send with 11 clock pulses.
    initial begin : device
        logic [10:0] got;
        logic [10:0] expf;
        logic        req_prev;
        logic        req_now;
        bit          aborted;
        req_prev = 1'b1;
        forever begin
            @(negedge clk);
            req_now = !clk_oe && data_oe;
            if (req_now && !req_prev && dev_mode != 2) begin
                repeat (10) @(negedge clk);
                got       = '0;
                got[0]    = ps2_data_w;
                dev_falls = 0;
                aborted   = 1'b0;
                for (int k = 1; k <= 11 && !aborted; k++) begin
                    if (k == 11) dev_data_low = (dev_mode == 0);
                    dev_wait(aborted);
                    if (!aborted) begin
                        dev_clk_low = 1'b1;
                        dev_falls++;
                    end
                    dev_wait(aborted);
                    dev_clk_low = 1'b0;
                    if (!aborted && k <= 10) got[k] = ps2_data_w;
                end
                if (aborted) begin
                    dev_abort    = 1'b0;
                    dev_data_low = 1'b0;
                end else begin
                    repeat (5) @(negedge clk);
                    dev_data_low = 1'b0;
                    check("frame_expected", 32'(frame_q.size() != 0), 32'd1);
                    if (frame_q.size() != 0) begin
                        expf = frame_q.pop_front();
                        check("frame_bits", 32'(got), 32'(expf));
                    end
                    if (dev_mode == 3) dev_mode = 0;
                end
                req_prev = 1'b1;
            end else begin
                req_prev = req_now;
            end
        end
    end

    // Outcome monitor: every pulse must match the next expected outcome.
    initial begin : monitor
        bit   pulse_prev;
        logic expo;
        pulse_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (pulse_prev) begin
                check("ready_after_pulse", 32'(tx_ready), 32'd1);
                check("oe_after_pulse", 32'({clk_oe, data_oe}), 32'd0);
            end
            pulse_prev = 1'b0;
            if (done || err) begin
                pulse_prev = 1'b1;
                check("done_err_exclusive", 32'(done & err), 32'd0);
                if (outcome_q.size() == 0) begin
                    check("unexpected_pulse", 32'({done, err}), 32'd0);
                end else begin
                    expo = outcome_q.pop_front();
                    check("outcome_done", 32'(done), 32'(expo));
                    check("outcome_err", 32'(err), 32'(!expo));
                end
                if (done) n_done++;
                if (err)  n_err++;
            end
        end
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int cnt;
        int since;
        int snap_done;
        int snap_err;
        int c;
        bit seen;
        logic prev_oe;
        logic [7:0] pbytes [3];

        // Reset and idle
        reset = 1'b1;
        repeat (4) @(negedge clk);
        check("reset_tx_ready", 32'(tx_ready), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_oe", 32'({clk_oe, data_oe}), 32'd0);
        check("reset_pulses", 32'({done, err}), 32'd0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_oe", 32'({clk_oe, data_oe}), 32'd0);

        // 0xED with inhibit length measurement
        frame_q.push_back(exp_frame(8'hED));
        outcome_q.push_back(1'b1);
        send(8'hED);
        check("accept_busy", 32'(busy), 32'd1);
        cnt = 0;
        while (clk_oe && cnt < INH + 50) begin
            cnt++;
            @(negedge clk);
        end
        check("inhibit_len", 32'(cnt), 32'(INH));
        check("req_start_bit", 32'({clk_oe, data_oe}), 32'b01);
        wait_outcome("ed_outcome_seen", 3000);
        check("ed_done_count", 32'(n_done), 32'd1);

        // Parity cases
        pbytes[0] = 8'h01;
        pbytes[1] = 8'hFF;
        pbytes[2] = 8'h00;
        for (int i = 0; i < 3; i++) begin
            snap_done = n_done;
            frame_q.push_back(exp_frame(pbytes[i]));
            outcome_q.push_back(1'b1);
            send(pbytes[i]);
            wait_outcome("parity_outcome_seen", 3000);
            check("parity_done", 32'(n_done - snap_done), 32'd1);
        end

        // Missing ACK
        snap_done = n_done;
        snap_err  = n_err;
        dev_mode  = 1;
        frame_q.push_back(exp_frame(8'h5A));
`ifdef PS2_HOST_TX_RETRY_EN
        frame_q.push_back(exp_frame(8'h5A));
`endif
        outcome_q.push_back(1'b0);
        send(8'h5A);
        wait_outcome("nack_outcome_seen", 6000);
        check("nack_err", 32'(n_err - snap_err), 32'd1);
        check("nack_no_done", 32'(n_done), 32'(snap_done));

        // Silent device, with tx_valid pulsed while busy
        repeat (5) @(negedge clk);
        dev_mode  = 2;
        snap_done = n_done;
        outcome_q.push_back(1'b0);
        send(8'h55);
        since   = -1;
        prev_oe = 1'b1;
        seen    = 1'b0;
        for (c = 0; c < 3000 && !seen; c++) begin
            @(negedge clk);
            if (c == 10) begin
                tx_data  = 8'hAA;
                tx_valid = 1'b1;
            end
            if (c == INH + 50) tx_valid = 1'b0;
            if (prev_oe && !clk_oe) since = 0;
            else if (since >= 0)    since++;
            prev_oe = clk_oe;
            if (err) begin
                seen = 1'b1;
                check("silent_err_delay", 32'(since), 32'(EDGE));
            end
        end
        tx_valid = 1'b0;
        check("silent_err_seen", 32'(seen), 32'd1);
        repeat (20) @(negedge clk);
        check("no_resend_busy", 32'(busy), 32'd0);
        check("silent_no_done", 32'(n_done), 32'(snap_done));

        // Reset in the middle of the data bits
        dev_mode  = 0;
        dev_falls = 0;
        snap_done = n_done;
        snap_err  = n_err;
        send(8'h3C);
        c = 0;
        while (dev_falls < 4 && c < 2000) begin
            @(negedge clk);
            c++;
        end
        check("reached_bit3", 32'(dev_falls >= 4), 32'd1);
        repeat (5) @(negedge clk);
        dev_abort = 1'b1;
        reset     = 1'b1;
        @(negedge clk);
        check("midreset_oe", 32'({clk_oe, data_oe}), 32'd0);
        check("midreset_ready", 32'(tx_ready), 32'd1);
        check("midreset_pulses", 32'({done, err}), 32'd0);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        check("midreset_no_outcome", 32'((n_done - snap_done) + (n_err - snap_err)), 32'd0);

        // Normal send after the aborted frame
        frame_q.push_back(exp_frame(8'hF4));
        outcome_q.push_back(1'b1);
        send(8'hF4);
        wait_outcome("f4_outcome_seen", 3000);
        check("f4_done", 32'(n_done - snap_done), 32'd1);

`ifdef PS2_HOST_TX_RETRY_EN
        // One NACK then ACK: a single done, no err
        snap_done = n_done;
        snap_err  = n_err;
        dev_mode  = 3;
        frame_q.push_back(exp_frame(8'hA5));
        frame_q.push_back(exp_frame(8'hA5));
        outcome_q.push_back(1'b1);
        send(8'hA5);
        wait_outcome("retry_outcome_seen", 6000);
        check("retry_done", 32'(n_done - snap_done), 32'd1);
        check("retry_no_err", 32'(n_err), 32'(snap_err));
`endif

        repeat (20) @(negedge clk);
        check("outcome_queue_empty", 32'(outcome_q.size()), 32'd0);
        check("frame_queue_empty", 32'(frame_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
